booth_mul_scheduler: RTL
========================

Name: booth_mul_scheduler

Overview:
Shares one iterative radix-2 Booth signed multiplier among NUM_REQ requesters.
- Arbitrates requests round-robin.
- Latches the winner's operands, sequences WIDTH Booth add/sub-and-shift steps, then returns the product tagged with the requester index through a valid/ready handshake.
- Sits between the arithmetic clients and the shared multiplier datapath; it is the only master of that datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
WIDTH, 4, operand width in bits, signed two's complement (2..16)
ID_W, $clog2(NUM_REQ), width of the requester index tag

Ports:
Clk  input  1  clock; all state changes on rising edge
Rst  input  1  asynchronous, active-high reset
Req  input  NUM_REQ  per-requester request, level
Multiplicand_flat  input  NUM_REQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH]
Multiplier_flat  input  NUM_REQ*WIDTH  operand B of requester i, same packing
Gnt  output  NUM_REQ  one-hot, one-cycle pulse: operands of that requester were captured
Busy  output  1  high from the capture edge until the result is accepted
Resp_valid  output  1  product available
Resp_ready  input  1  consumer accepts product
Resp_id  output  ID_W  index of the requester that owns Result
Result  output  2*WIDTH  signed product

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE; Gnt=0, Busy=0, Resp_valid=0, Resp_id=0, Result=0; round-robin pointer=0; in-flight operation discarded, no response ever issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - Req sampled only here.
  - If Req != 0, pick the first set bit searching upward from pointer, with wrap-around.
  - On that edge:
    - capture winner's A into M and B into Q;
    - clear Acc and Qm1; Count=WIDTH;
    - Gnt=onehot(winner) for exactly one cycle; Busy=1;
    - pointer = winner+1 mod NUM_REQ;
    - go to RUN.
  - Req==0: stay in IDLE, outputs unchanged.
- RUN: one Booth step per cycle.
  - {Q[0],Qm1}=10: Acc-=M.
  - {Q[0],Qm1}=01: Acc+=M.
  - 00/11: no add.
  - Then arithmetic right shift of {Acc,Q,Qm1}; Count-=1.
  - The step that brings Count to 0 also loads Result={Acc,Q} (low 2*WIDTH bits), Resp_id=winner, Resp_valid=1, and moves to DONE.
  - Req changes are ignored.
- DONE:
  - Result/Resp_id/Resp_valid held stable while Resp_ready=0 (no timeout).
  - On the edge with Resp_valid&Resp_ready: Resp_valid=0, Busy=0, go to IDLE. Result keeps its last value.
  - Next arbitration at the following edge at the earliest.
- Latency: Resp_valid rises exactly WIDTH cycles after the Gnt pulse. Minimum issue interval is WIDTH+2 cycles (accepting in the first DONE cycle).
- Width rules:
  - Acc is WIDTH+1 bits, sign-extended, so negating the most-negative multiplicand does not overflow.
  - Result is the exact signed product for all operand pairs, including (-2^(WIDTH-1))^2.
- Requester protocol: a requester drops Req the cycle after its Gnt. If Req is still high in a later IDLE cycle, that counts as a new request.
- Simultaneous events:
  - Requests arriving during RUN/DONE wait; no request is lost as long as Req is held.
  - A Req that rises in the same cycle as an IDLE arbitration is considered in that arbitration.
- Gnt is never asserted outside the IDLE->RUN edge; Gnt and Resp_valid are never both high.

Decomposition:
- Shared package booth_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - Booth decode constants (BOOTH_NOP0=2'b00, BOOTH_ADD=2'b01, BOOTH_SUB=2'b10, BOOTH_NOP1=2'b11);
  - default WIDTH/NUM_REQ constants.
- One sub-module, booth_step_core: the Acc/Q/Qm1/Count datapath.
  - Inputs: Clk, Rst, load, A, B.
  - Outputs: done pulse, product.
- The scheduler keeps the arbiter, pointer, FSM and response registers.

Test Plan:
- Single request, WIDTH=4: Req=0001, A=3, B=5 → Gnt=0001 one cycle; Resp_valid 4 cycles later; Result=8'h0F, Resp_id=0.
- Sign corners: (-8)*(-8) → 8'h40; (-8)*7 → 8'hC8; (-1)*(-1) → 8'h01; 0*(-8) → 8'h00; exhaustive 256-pair sweep matches A*B.
- Fairness: Req=1111 held, each requester drops Req after its Gnt → grant order 0,1,2,3. Then only Req=0001 with pointer=1 → grant 0 via wrap-around.
- Backpressure: Resp_ready=0 for 10 cycles with Req=0010 pending → Result/Resp_id stable, no Gnt. Resp_ready=1 → accept, then Gnt=0010 on the next edge.
- Reset mid-RUN (2 steps done) → Busy, Resp_valid and Gnt all 0 immediately. After release, Req=0100 is granted first (pointer reset) with a correct fresh product and no stale response.
- Back-to-back: Resp_ready tied 1, two requesters alternating → issue interval exactly WIDTH+2 = 6 cycles, results correctly tagged.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the round-robin Booth multiplier scheduler.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Booth decode of {Q[0], Qm1}
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/booth_step_core.sv
// Iterative radix-2 Booth datapath: one add/sub-and-shift per cycle after load.
// product shows the post-step value, so it is valid on the cycle done is high.
module booth_step_core
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc carries one guard bit so -M of the most-negative operand fits
    logic [WIDTH:0]     m;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_nx;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   q_nx;
    logic               qm1;
    logic [CNT_W-1:0]   count;

    always_comb begin
        sum = acc;
        case ({q[0], qm1})
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
        acc_nx = {sum[WIDTH], sum[WIDTH:1]};
        q_nx   = {sum[0], q[WIDTH-1:1]};
    end

    assign done    = (count == CNT_W'(1));
    assign product = {acc_nx[WIDTH-1:0], q_nx};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m     <= '0;
            acc   <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            count <= '0;
        end else if (load) begin
            m     <= {A[WIDTH-1], A};
            acc   <= '0;
            q     <= B;
            qm1   <= 1'b0;
            count <= CNT_W'(WIDTH);
        end else if (count != '0) begin
            acc   <= acc_nx;
            q     <= q_nx;
            qm1   <= q[0];
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Round-robin front end for one shared Booth multiplier: arbitrates in IDLE,
// steps the core in RUN, and holds the tagged product in DONE until accepted.
module booth_mul_scheduler
    import booth_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [NUM_REQ*WIDTH-1:0]   Multiplicand_flat,
    input  logic [NUM_REQ*WIDTH-1:0]   Multiplier_flat,
    output logic [NUM_REQ-1:0]         Gnt,
    output logic                       Busy,
    output logic                       Resp_valid,
    input  logic                       Resp_ready,
    output logic [ID_W-1:0]            Resp_id,
    output logic [2*WIDTH-1:0]         Result
);

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    cur_id;
    logic [ID_W-1:0]    win_id;
    logic               win_vld;
    logic               load;
    logic [WIDTH-1:0]   win_a;
    logic [WIDTH-1:0]   win_b;
    logic               core_done;
    logic [2*WIDTH-1:0] core_prod;

    // first set request at or above ptr, wrapping past NUM_REQ-1
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!win_vld && Req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    assign win_a = Multiplicand_flat[int'(win_id)*WIDTH +: WIDTH];
    assign win_b = Multiplier_flat[int'(win_id)*WIDTH +: WIDTH];
    assign load  = (state == IDLE) && win_vld;

    booth_step_core #(.WIDTH(WIDTH)) u_core (
        .Clk     (Clk),
        .Rst     (Rst),
        .load    (load),
        .A       (win_a),
        .B       (win_b),
        .done    (core_done),
        .product (core_prod)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            ptr        <= '0;
            cur_id     <= '0;
            Gnt        <= '0;
            Busy       <= 1'b0;
            Resp_valid <= 1'b0;
            Resp_id    <= '0;
            Result     <= '0;
        end else begin
            Gnt <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        Gnt    <= NUM_REQ'(1) << win_id;
                        Busy   <= 1'b1;
                        cur_id <= win_id;
                        ptr    <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        Result     <= core_prod;
                        Resp_id    <= cur_id;
                        Resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (Resp_ready) begin
                        Resp_valid <= 1'b0;
                        Busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
